// File: rtl/bcd3_to_bin_seq_if.sv
// Handshake and data bundle for bcd3_to_bin_seq: digit request in, binary result out.
interface bcd3_to_bin_seq_if;
    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    logic [9:0] a;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output start, x, y, z, input a, busy, done, err);
    modport slave  (input start, x, y, z, output a, busy, done, err);
endinterface

// File: rtl/bcd3_to_bin_seq.sv
// Sequential 3-digit BCD to 10-bit binary converter (reverse double-dabble, 10 iterations).
// Define BCD2BIN_RANGE_CHK_EN to reject digits > 9 with err and a one-cycle completion.
module bcd3_to_bin_seq (
    input logic               clk,
    input logic               rst_n,
    bcd3_to_bin_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01} state_t;

    state_t      state, state_nx;
    logic [11:0] bcd, bcd_nx;
    logic [9:0]  bin, bin_nx;
    logic [3:0]  cnt;
    logic [9:0]  a_q;
    logic        busy_q, done_q;
    logic        last;
    logic        bad;
    logic [21:0] shifted;

    function automatic logic [3:0] adj(input logic [3:0] n);
        return (n >= 4'd8) ? n - 4'd3 : n;
    endfunction

    // One iteration: shift the whole {bcd,bin} right, then correct each BCD nibble.
    always_comb begin
        shifted = {1'b0, bcd, bin[9:1]};
        bcd_nx  = {adj(shifted[21:18]), adj(shifted[17:14]), adj(shifted[13:10])};
        bin_nx  = shifted[9:0];
        last    = (cnt == 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (bad || last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd    <= '0;
            bin    <= '0;
            cnt    <= '0;
            a_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bcd    <= {bus.x, bus.y, bus.z};
                        bin    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bad) begin
                        a_q    <= '0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        bcd <= bcd_nx;
                        bin <= bin_nx;
                        cnt <= cnt + 4'd1;
                        if (last) begin
                            a_q    <= bin_nx;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD2BIN_RANGE_CHK_EN
    logic err_q;

    // Digit validity is latched at capture; the first SHIFT cycle then ends the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad   <= 1'b0;
            err_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            bad   <= (bus.x > 4'd9) || (bus.y > 4'd9) || (bus.z > 4'd9);
            err_q <= 1'b0;
        end else if (state == SHIFT && bad) begin
            bad   <= 1'b0;
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bad     = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign bus.a    = a_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
